// File: rtl/decode_unit_basic.sv
// Single-entry decode stage: latches one fetched RV32I ALU-subset instruction and decodes it for execute.
// Optional MUL decode is enabled by defining DECODE_UNIT_MUL_EN.
module decode_unit_basic #(
  parameter int unsigned p_seq_num_bits = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      F_val,
  output logic                      F_rdy,
  input  logic [31:0]               F_inst,
  input  logic [31:0]               F_pc,
  input  logic                      squash,
  output logic                      X_val,
  input  logic                      X_rdy,
  output logic [31:0]               X_pc,
  output logic [p_seq_num_bits-1:0] X_seq_num,
  output logic [3:0]                X_op,
  output logic [4:0]                X_rd,
  output logic [4:0]                X_rs1,
  output logic [4:0]                X_rs2,
  output logic [31:0]               X_imm,
  output logic                      X_uses_rs1,
  output logic                      X_uses_rs2,
  output logic                      X_wen
);

  localparam logic [3:0] OP_ILLEGAL = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_SUB     = 4'd2;
  localparam logic [3:0] OP_AND     = 4'd3;
  localparam logic [3:0] OP_OR      = 4'd4;
  localparam logic [3:0] OP_XOR     = 4'd5;
  localparam logic [3:0] OP_SLL     = 4'd6;
  localparam logic [3:0] OP_SRL     = 4'd7;
  localparam logic [3:0] OP_SRA     = 4'd8;
  localparam logic [3:0] OP_SLT     = 4'd9;
  localparam logic [3:0] OP_SLTU    = 4'd10;
  localparam logic [3:0] OP_ADDI    = 4'd11;
  localparam logic [3:0] OP_LUI     = 4'd12;
`ifdef DECODE_UNIT_MUL_EN
  localparam logic [3:0] OP_MUL     = 4'd13;
`endif

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  logic                      valid_q;
  logic [31:0]               inst_q;
  logic [31:0]               pc_q;
  logic [p_seq_num_bits-1:0] seq_q;

  logic       f_xfer;
  logic       x_xfer;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  // Handshake: a squash frees the slot in the same cycle it kills the held entry
  assign F_rdy  = !rst && (!valid_q || X_rdy || squash);
  assign X_val  = valid_q && !squash;
  assign f_xfer = F_val && F_rdy;
  assign x_xfer = X_val && X_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
      seq_q   <= '0;
    end else begin
      if (squash) begin
        valid_q <= 1'b0;
      end else if (f_xfer) begin
        valid_q <= 1'b1;
        inst_q  <= F_inst;
        pc_q    <= F_pc;
      end else if (x_xfer) begin
        valid_q <= 1'b0;
      end
      if (x_xfer) begin
        seq_q <= seq_q + p_seq_num_bits'(1);
      end
    end
  end

  assign opcode    = inst_q[6:0];
  assign f3        = inst_q[14:12];
  assign f7        = inst_q[31:25];
  assign X_pc      = pc_q;
  assign X_seq_num = seq_q;
  assign X_rd      = inst_q[11:7];
  assign X_rs1     = inst_q[19:15];
  assign X_rs2     = inst_q[24:20];
  assign X_wen     = (X_op != OP_ILLEGAL) && (X_rd != 5'd0);

  // Field decode; anything unrecognised stays ILLEGAL with no operand reads
  always_comb begin
    X_op       = OP_ILLEGAL;
    X_imm      = 32'd0;
    X_uses_rs1 = 1'b0;
    X_uses_rs2 = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  X_op = OP_ADD;
            3'b001:  X_op = OP_SLL;
            3'b010:  X_op = OP_SLT;
            3'b011:  X_op = OP_SLTU;
            3'b100:  X_op = OP_XOR;
            3'b101:  X_op = OP_SRL;
            3'b110:  X_op = OP_OR;
            default: X_op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          X_op = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          X_op = OP_SRA;
`ifdef DECODE_UNIT_MUL_EN
        end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
          X_op = OP_MUL;
`endif
        end
        if (X_op != OP_ILLEGAL) begin
          X_uses_rs1 = 1'b1;
          X_uses_rs2 = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if (f3 == 3'b000) begin
          X_op       = OP_ADDI;
          X_imm      = {{20{inst_q[31]}}, inst_q[31:20]};
          X_uses_rs1 = 1'b1;
        end
      end
      OPC_LUI: begin
        X_op  = OP_LUI;
        X_imm = {inst_q[31:12], 12'd0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decode_unit_basic.sv
// Bench for decode_unit_basic: directed decode table, handshake corner sequences and random traffic vs a reference model.
module tb_decode_unit_basic;

`ifdef DECODE_UNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        F_val = 1'b0;
  logic        F_rdy;
  logic [31:0] F_inst = 32'd0;
  logic [31:0] F_pc = 32'd0;
  logic        squash = 1'b0;
  logic        X_val;
  logic        X_rdy = 1'b0;
  logic [31:0] X_pc;
  logic [7:0]  X_seq_num;
  logic [3:0]  X_op;
  logic [4:0]  X_rd, X_rs1, X_rs2;
  logic [31:0] X_imm;
  logic        X_uses_rs1, X_uses_rs2, X_wen;

  always #5 clk = ~clk;

  decode_unit_basic #(.p_seq_num_bits(8)) dut (
    .clk(clk), .rst(rst), .F_val(F_val), .F_rdy(F_rdy), .F_inst(F_inst), .F_pc(F_pc),
    .squash(squash), .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_op(X_op), .X_rd(X_rd), .X_rs1(X_rs1), .X_rs2(X_rs2), .X_imm(X_imm),
    .X_uses_rs1(X_uses_rs1), .X_uses_rs2(X_uses_rs2), .X_wen(X_wen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] imm;
    logic        u1;
    logic        u2;
    logic        wen;
  } dec_t;

  // Reference decoder written from the instruction-set tables
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int   r0_ops[8] = '{1, 6, 9, 10, 5, 7, 4, 3};
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    d = '0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00)                       d.op = 4'(r0_ops[f3]);
      else if (f7 == 7'h20 && f3 == 3'd0)    d.op = 4'd2;
      else if (f7 == 7'h20 && f3 == 3'd5)    d.op = 4'd8;
      else if (f7 == 7'h01 && f3 == 3'd0 && MUL_EN) d.op = 4'd13;
    end else if (opc == 7'h13 && f3 == 3'd0) begin
      d.op  = 4'd11;
      d.imm = 32'($signed(w[31:20]));
    end else if (opc == 7'h37) begin
      d.op  = 4'd12;
      d.imm = w & 32'hFFFF_F000;
    end
    if (d.op != 4'd0) begin
      d.u1 = (d.op != 4'd12);
      d.u2 = (d.op <= 4'd10) || (d.op == 4'd13);
    end
    d.wen = (d.op != 4'd0) && (w[11:7] != 5'd0);
    return d;
  endfunction

  // Model state: at most one held instruction plus the next tag to hand out
  bit          m_valid = 1'b0;
  logic [31:0] m_inst  = 32'd0;
  logic [31:0] m_pc    = 32'd0;
  logic [7:0]  m_seq   = 8'd0;

  task automatic cycle(input logic r, input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic xr, input logic sq);
    dec_t d;
    bit   fx, xx;
    @(negedge clk);
    rst = r; F_val = fv; F_inst = inst; F_pc = pc; X_rdy = xr; squash = sq;
    #1;
    if (r) begin
      check("f_rdy_in_reset", 32'(F_rdy), 32'd0);
    end else begin
      check("f_rdy", 32'(F_rdy), 32'(!m_valid || xr || sq));
      check("x_val", 32'(X_val), 32'(m_valid && !sq));
      if (m_valid && !sq) begin
        d = ref_decode(m_inst);
        check("x_pc", X_pc, m_pc);
        check("x_seq", 32'(X_seq_num), 32'(m_seq));
        check("x_op", 32'(X_op), 32'(d.op));
        check("x_rd", 32'(X_rd), 32'(m_inst[11:7]));
        check("x_rs1", 32'(X_rs1), 32'(m_inst[19:15]));
        check("x_rs2", 32'(X_rs2), 32'(m_inst[24:20]));
        check("x_imm", X_imm, d.imm);
        check("x_uses_rs1", 32'(X_uses_rs1), 32'(d.u1));
        check("x_uses_rs2", 32'(X_uses_rs2), 32'(d.u2));
        check("x_wen", 32'(X_wen), 32'(d.wen));
      end
    end
    if (r) begin
      m_valid = 1'b0;
      m_seq   = 8'd0;
    end else begin
      fx = fv && (!m_valid || xr || sq);
      xx = m_valid && !sq && xr;
      if (sq)      m_valid = 1'b0;
      else if (fx) begin m_valid = 1'b1; m_inst = inst; m_pc = pc; end
      else if (xx) m_valid = 1'b0;
      if (xx) m_seq = m_seq + 8'd1;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    logic [6:0]  f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    case ($urandom_range(0, 4))
      0: w = {f7s[$urandom_range(0, 3)], w[24:7], 7'h33};
      1: w = {w[31:7], 7'h13};
      2: w = {w[31:7], 7'h37};
      3: w = {w[31:15], 3'd0, w[11:7], 7'h13};
      default: ;
    endcase
    return w;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wen;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [7:0] seq_before;

    tbl[0]  = '{32'h00A00093, 4'd11, 5'd1, 32'h0000000A, 1'b1};
    tbl[1]  = '{32'h002081B3, 4'd1,  5'd3, 32'h00000000, 1'b1};
    tbl[2]  = '{32'h40208233, 4'd2,  5'd4, 32'h00000000, 1'b1};
    tbl[3]  = '{32'hFFFFF2B7, 4'd12, 5'd5, 32'hFFFFF000, 1'b1};
    tbl[4]  = '{32'h0000007F, 4'd0,  5'd0, 32'h00000000, 1'b0};
    tbl[5]  = '{32'h022081B3, MUL_EN ? 4'd13 : 4'd0, 5'd3, 32'h00000000, MUL_EN};
    tbl[6]  = '{32'hFFF00013, 4'd11, 5'd0, 32'hFFFFFFFF, 1'b0};
    tbl[7]  = '{32'h4020D1B3, 4'd8,  5'd3, 32'h00000000, 1'b1};
    tbl[8]  = '{32'h4020C1B3, 4'd0,  5'd3, 32'h00000000, 1'b0};
    tbl[9]  = '{32'h0020F1B3, 4'd3,  5'd3, 32'h00000000, 1'b1};
    tbl[10] = '{32'h00109093, 4'd0,  5'd1, 32'h00000000, 1'b0};

    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("reset_x_val", 32'(X_val), 32'd0);
    check("reset_f_rdy", 32'(F_rdy), 32'd1);

    // Back-to-back decode table, one per cycle, seq starting at 0
    for (int i = 0; i <= 11; i++) begin
      cycle(1'b0, i < 11, (i < 11) ? tbl[i].inst : 32'd0, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      if (i > 0) begin
        check("tbl_val", 32'(X_val), 32'd1);
        check("tbl_op", 32'(X_op), 32'(tbl[i-1].op));
        check("tbl_rd", 32'(X_rd), 32'(tbl[i-1].rd));
        check("tbl_imm", X_imm, tbl[i-1].imm);
        check("tbl_wen", 32'(X_wen), 32'(tbl[i-1].wen));
        check("tbl_pc", X_pc, 32'h200 + 32'(4 * (i - 1)));
        check("tbl_seq", 32'(X_seq_num), 32'(i - 1));
      end
    end

    // Stall three cycles, then release
    cycle(1'b0, 1'b1, 32'h002081B3, 32'h300, 1'b1, 1'b0);
    seq_before = X_seq_num;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'hFFFFF2B7, 32'h304, 1'b0, 1'b0);
      check("stall_f_rdy", 32'(F_rdy), 32'd0);
      check("stall_pc", X_pc, 32'h300);
      check("stall_op", 32'(X_op), 32'd1);
    end
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("stall_seq_once", 32'(X_seq_num), 32'(seq_before + 8'd1));

    // Squash with a held instruction and an incoming one
    cycle(1'b0, 1'b1, 32'h00A00093, 32'h400, 1'b1, 1'b0);
    seq_before = X_seq_num;
    cycle(1'b0, 1'b1, 32'h40208233, 32'h404, 1'b1, 1'b1);
    check("squash_hides_x", 32'(X_val), 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("squash_empty", 32'(X_val), 32'd0);
    check("squash_seq", 32'(X_seq_num), 32'(seq_before));

    // 257 instructions at full rate to wrap the tag, then reset mid-stream
    for (int i = 0; i < 257; i++)
      cycle(1'b0, 1'b1, rand_inst(), 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h00A00093, 32'h2000, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("rst_mid_x_val", 32'(X_val), 32'd0);
    cycle(1'b0, 1'b1, 32'h00A00093, 32'h2004, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("rst_mid_seq", 32'(X_seq_num), 32'd0);

    // Random traffic with occasional squash and reset
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rand_inst(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
